// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and data bus between a controller and serial_adder.
// fsm_state mirrors the adder's internal state so checkers can observe it.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic [1:0]       fsm_state;

   // start is sampled on every rising edge and accepted only when busy is low;
   // a, b and c are captured on that same edge. done pulses one cycle with s/cout valid.
   modport master (
      output start, a, b, c,
      input  busy, done, s, cout, fsm_state
   );

   modport slave (
      input  start, a, b, c,
      output busy, done, s, cout, fsm_state
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder evaluation per clock, LSB first,
// with the carry held in a flip-flop between steps.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   serial_adder_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] psum;
   logic [WIDTH-1:0] psum_next;
   logic [WIDTH-1:0] s_reg;
   logic             carry;
   logic             cout_reg;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_cout;
   logic             accept;
   logic             last_step;

   fulladder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign accept    = bus.start && (state != RUN);
   assign last_step = (state == RUN) && (cnt == LAST);
   // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
   assign psum_next = (psum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (cnt == LAST) state_next = DONE;
         DONE:    state_next = bus.start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         psum     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         s_reg    <= '0;
         cout_reg <= 1'b0;
      end else if (accept) begin
         a_sr  <= bus.a;
         b_sr  <= bus.b;
         carry <= bus.c;
         psum  <= '0;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         carry <= fa_cout;
         psum  <= psum_next;
         cnt   <= cnt + 1'b1;
         // Outputs only move on completion; they hold the old result during RUN.
         if (last_step) begin
            s_reg    <= psum_next;
            cout_reg <= fa_cout;
         end
      end
   end

   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.s         = s_reg;
   assign bus.cout      = cout_reg;
   assign bus.fsm_state = state;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance checked every cycle against a
// transaction-level model, plus an exhaustive WIDTH=1 instance.
module tb_serial_adder;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   bit   chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   serial_adder_if #(.WIDTH(W)) bus8 ();
   serial_adder_if #(.WIDTH(1)) bus1 ();

   serial_adder #(.WIDTH(W)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model (WIDTH=8) ----------------
   logic [W:0]   exp_q[$];
   bit           m_busy = 1'b0;
   bit           m_done = 1'b0;
   int           m_left = 0;
   logic [W-1:0] m_s = '0;
   logic         m_cout = 1'b0;
   logic [W:0]   m_pend = '0;

   // An addition is an opaque WIDTH-cycle delay that yields a+b+c.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_left = 0;
         m_s    = '0;
         m_cout = 1'b0;
         exp_q.delete();
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            {m_cout, m_s} = m_pend;
         end
      end else begin
         m_done = 1'b0;
         if (bus8.start) begin
            m_pend = {1'b0, bus8.a} + {1'b0, bus8.b} + {{W{1'b0}}, bus8.c};
            exp_q.push_back(m_pend);
            m_left = W;
            m_busy = 1'b1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(bus8.busy), 32'(m_busy));
         chk("done", 32'(bus8.done), 32'(m_done));
         chk("s", 32'(bus8.s), 32'(m_s));
         chk("cout", 32'(bus8.cout), 32'(m_cout));
         chk("busy_and_done", 32'(bus8.busy & bus8.done), 32'd0);
         if (m_done) begin
            if (exp_q.size() == 0) chk("exp_q_empty", 32'd1, 32'd0);
            else chk("result", 32'({bus8.cout, bus8.s}), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic st);
      bus8.a = a;
      bus8.b = b;
      bus8.c = c;
      bus8.start = st;
   endtask

   task automatic wait_done8(output int dcyc, output int busy_n);
      bit ok;
      ok = 1'b0;
      dcyc = 0;
      busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus8.busy) busy_n++;
         if (bus8.done) begin
            ok = 1'b1;
            dcyc = cyc;
            break;
         end
      end
      chk("done_seen", 32'(ok), 32'd1);
   endtask

   // Issues one addition from idle and checks latency, busy span and literal result.
   task automatic run8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] exp_s, input logic exp_cout);
      int e0, dcyc, busy_n;
      @(posedge clk); #1;
      drive8(a, b, c, 1'b1);
      @(posedge clk); #1;
      e0 = cyc;
      bus8.start = 1'b0;
      wait_done8(dcyc, busy_n);
      chk("latency", 32'(dcyc - e0), 32'(W));
      chk("busy_cycles", 32'(busy_n), 32'(W));
      chk("lit_s", 32'(bus8.s), 32'(exp_s));
      chk("lit_cout", 32'(bus8.cout), 32'(exp_cout));
   endtask

   task automatic count_done8(input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (bus8.done) n++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e0, d1, d2, busy_n, n;
      logic [1:0] exp1;
      drive8('0, '0, 1'b0, 1'b0);
      bus1.a = '0;
      bus1.b = '0;
      bus1.c = 1'b0;
      bus1.start = 1'b0;

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", 32'(bus8.busy), 32'd0);
      chk("rst_done", 32'(bus8.done), 32'd0);
      chk("rst_s", 32'(bus8.s), 32'd0);
      chk("rst_cout", 32'(bus8.cout), 32'd0);

      // Basic add and carry propagation.
      run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // Operand and start isolation during RUN.
      @(posedge clk); #1;
      drive8(8'h10, 8'h20, 1'b0, 1'b1);
      @(posedge clk); #1;
      bus8.start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      drive8(8'hAA, 8'hAA, 1'b1, 1'b1);
      @(negedge clk);
      chk("hold_s", 32'(bus8.s), 32'hFF);
      @(posedge clk); #1;
      bus8.start = 1'b0;
      wait_done8(d1, busy_n);
      chk("iso_s", 32'(bus8.s), 32'h30);
      chk("iso_cout", 32'(bus8.cout), 32'd0);
      count_done8(15, n);
      chk("iso_no_second_done", 32'(n), 32'd0);

      // Back-to-back with start held high.
      @(posedge clk); #1;
      drive8(8'h01, 8'h01, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive8(8'h80, 8'h80, 1'b0, 1'b1);
      wait_done8(d1, busy_n);
      chk("b2b_s1", 32'(bus8.s), 32'h02);
      chk("b2b_cout1", 32'(bus8.cout), 32'd0);
      @(posedge clk); #1;
      bus8.start = 1'b0;
      wait_done8(d2, busy_n);
      chk("b2b_gap", 32'(d2 - d1), 32'(W + 1));
      chk("b2b_s2", 32'(bus8.s), 32'h00);
      chk("b2b_cout2", 32'(bus8.cout), 32'd1);

      // Asynchronous reset in the middle of RUN.
      @(posedge clk); #1;
      drive8(8'h33, 8'h44, 1'b0, 1'b1);
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus8.busy), 32'd0);
      chk("arst_done", 32'(bus8.done), 32'd0);
      chk("arst_s", 32'(bus8.s), 32'd0);
      chk("arst_cout", 32'(bus8.cout), 32'd0);
      @(negedge clk) rst = 1'b0;
      count_done8(15, n);
      chk("arst_no_done", 32'(n), 32'd0);
      run8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

      // WIDTH=1 exhaustive.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         @(posedge clk); #1;
         bus1.a = v[2];
         bus1.b = v[1];
         bus1.c = v[0];
         bus1.start = 1'b1;
         @(posedge clk); #1;
         e0 = cyc;
         bus1.start = 1'b0;
         @(negedge clk);
         chk("w1_busy", 32'(bus1.busy), 32'd1);
         chk("w1_no_done_yet", 32'(bus1.done), 32'd0);
         @(negedge clk);
         chk("w1_done", 32'(bus1.done), 32'd1);
         chk("w1_latency", 32'(cyc - e0), 32'd1);
         exp1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
         chk("w1_sum", 32'({bus1.cout, bus1.s}), 32'(exp1));
      end

      // Random traffic: start toggling freely, operands changing every cycle, rare resets.
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         drive8(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 249) == 0) begin
            #2 rst = 1'b1;
            #3 rst = 1'b0;
         end
      end
      bus8.start = 1'b0;
      repeat (W + 3) @(posedge clk);
      @(negedge clk);
      chk("drain_q", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the team's one-bit `fulladder` cell: one full-adder evaluation per clock, with the carry held in a flip-flop between cycles. Sits directly downstream of `fulladder`: it consumes the cell's `s`/`cout` each cycle and assembles a full-width sum. Provides a start/busy/done handshake so a controller can issue additions and collect results without holding the operands stable.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request an addition; sampled on the rising edge of `clk`.
- `a`  input  WIDTH  operand A; sampled only on an accepted `start`.
- `b`  input  WIDTH  operand B; sampled only on an accepted `start`.
- `c`  input  1  carry-in; sampled only on an accepted `start`.
- `busy`  output  1  high while an addition is in progress.
- `done`  output  1  one-cycle pulse; result valid.
- `s`  output  WIDTH  sum register.
- `cout`  output  1  final carry-out register.

## Operation
- States:
  - IDLE: no addition pending.
  - RUN: WIDTH bit-steps in progress.
  - DONE: result just produced; lasts exactly one cycle.
- Accept rule: `start` is accepted when the state is IDLE or DONE.
  - On an accepted edge: load `a` and `b` into shift registers, load the carry flip-flop from `c`, clear the bit counter, go to RUN.
  - `start` in RUN is ignored.
- Each RUN cycle:
  - One `fulladder` instance computes from operand LSBs and the carry flip-flop.
  - The sum bit shifts into the partial-sum register at the MSB side.
  - Operand registers shift right by one.
  - The carry flip-flop takes the cell's `cout`.
  - The counter increments.
- On the edge that processes bit WIDTH-1:
  - Copy the partial sum into `s` and the final carry into `cout`.
  - Go to DONE.
- DONE:
  - If `start` is high, accept it (go to RUN).
  - Otherwise go to IDLE.
- Outputs:
  - `busy` = (state == RUN).
  - `done` = (state == DONE).
  - `s` and `cout` change only on the completion edge or on reset, and hold the previous result throughout a new RUN.
- Arithmetic: {`cout`,`s`} = `a` + `b` + `c`, computed modulo 2^(WIDTH+1); no overflow flag.
- Operand or `c` changes after acceptance have no effect on the result in flight.
- Reset:
  - `rst` high forces IDLE immediately, independent of `clk`.
  - `busy`=0, `done`=0, `s`=0, `cout`=0; shift registers, carry flip-flop and counter all 0.
  - Reset in the middle of a RUN aborts the addition; no `done` pulse follows.
  - The first `start` may be accepted on the first rising edge after `rst` deasserts.

## Timing
- Let edge E0 be the edge that accepts `start`.
  - `busy` is high from after E0 through the edge E_WIDTH.
  - Bit k is processed on edge E(k+1), for k = 0..WIDTH-1.
  - `s` and `cout` are updated at E_WIDTH.
  - `done` is high for the single cycle between E_WIDTH and E(WIDTH+1).
- Latency from the `start` edge to `done` high: WIDTH cycles.
- Throughput: one result per WIDTH+1 cycles when `start` is held high continuously; restart occurs at the DONE cycle's edge.
- `busy` and `done` are never high together.
- WIDTH=1: one RUN cycle, then DONE.

## Test plan
- Basic add, WIDTH=8: reset, then `a`=0x5A, `b`=0x3C, `c`=0, pulse `start` -> `busy` high for 8 cycles; `done` high exactly 8 cycles after the start edge; `s`=0x96, `cout`=0.
- Carry propagation: 0xFF+0x01, `c`=0 -> `s`=0x00, `cout`=1; then 0xFF+0xFF, `c`=1 -> `s`=0xFF, `cout`=1.
- Isolation of operands and `start`: start 0x10+0x20, then change `a`/`b` to 0xAA and pulse `start` at cycle 3 of RUN -> result `s`=0x30, `cout`=0; no second `done`; `s` holds its previous value until completion.
- Back-to-back: hold `start` high with 0x01+0x01 and then 0x80+0x80 -> `done` pulses 9 cycles apart; results are 0x02/0 then 0x00/1.
- Reset mid-operation: assert `rst` asynchronously at cycle 4 of RUN -> `busy`, `done`, `s`, `cout` go to 0 at once; no `done` pulse follows; the next addition is correct.
- WIDTH=1 exhaustive: all 8 combinations of `a`, `b`, `c` -> {`cout`,`s`} matches the full-adder truth table; `done` follows the start edge by 1 cycle.
